fetch_stage: RTL and testbench

Instruction-fetch front end of the 8-bit pipelined uP. It owns the PC, drives the synchronous instruction ROM (1-cycle read latency), and loads the IF/ID pipeline register that feeds the decoder. It resolves jump and branch redirects arriving from EX, flushes wrong-path instructions, and honours a decode-stage stall without losing the in-flight ROM word.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_pc_target.sv | 42 ++++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the 8-bit uP fetch front end: default widths, fetch FSM
// encoding and the bubble instruction.
package fetch_stage_pkg;

   localparam int unsigned DefPcW    = 10;
   localparam int unsigned DefInstrW = 16;
   localparam int unsigned DefOffW   = 6;
   localparam int unsigned RedirW    = 16;

   typedef enum logic {
      StFill = 1'b0,
      StRun  = 1'b1
   } fetchState_e;

   localparam logic [15:0] Bubble = 16'h0000;

endpackage

// File: rtl/fetch_pc_target.sv
// Redirect target selection (jump over branch, sign-extended branch offset) and the
// ROM address mux for the fetch stage.
module fetch_pc_target
   import fetch_stage_pkg::*;
#(
   parameter int unsigned PC_W  = DefPcW,
   parameter int unsigned OFF_W = DefOffW
) (
   input  logic             iStall,
   input  logic             iJmpEnable,
   input  logic [PC_W-1:0]  iJmpDir,
   input  logic             iBranchTaken,
   input  logic [PC_W-1:0]  iBranchPC,
   input  logic [OFF_W-1:0] iBranchOff,
   input  logic [PC_W-1:0]  iPC,
   input  logic [PC_W-1:0]  iPCF,
   output logic             oRedirect,
   output logic [PC_W-1:0]  oTarget,
   output logic [PC_W-1:0]  oRomAddr
);

   logic [PC_W-1:0] offExt;
   logic [PC_W-1:0] branchTarget;

   assign offExt       = {{(PC_W-OFF_W){iBranchOff[OFF_W-1]}}, iBranchOff};
   assign branchTarget = iBranchPC + offExt;

   assign oRedirect = iJmpEnable | iBranchTaken;
   assign oTarget   = iJmpEnable ? iJmpDir : branchTarget;

   // While stalled, re-read the in-flight word so iRomInstr stays valid.
   always_comb begin
      if (oRedirect) begin
         oRomAddr = oTarget;
      end else if (iStall) begin
         oRomAddr = iPCF;
      end else begin
         oRomAddr = iPC;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the 1-cycle ROM, loads IF/ID and
// handles EX redirects (one bubble) and decode stalls.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned PC_W     = DefPcW,
   parameter int unsigned INSTR_W  = DefInstrW,
   parameter int unsigned OFF_W    = DefOffW,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iStall,
   input  logic               iJmpEnable,
   input  logic [PC_W-1:0]    iJmpDir,
   input  logic               iBranchTaken,
   input  logic [PC_W-1:0]    iBranchPC,
   input  logic [OFF_W-1:0]   iBranchOff,
   output logic [PC_W-1:0]    oRomAddr,
   input  logic [INSTR_W-1:0] iRomInstr,
   output logic [INSTR_W-1:0] oInstrID,
   output logic [PC_W-1:0]    oPCID,
   output logic               oValidID,
   output logic               oFlushEX,
   output logic [RedirW-1:0]  oRedirects
);

   localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

   fetchState_e        stateQ, stateD;
   logic [PC_W-1:0]    pcQ, pcD;
   logic [PC_W-1:0]    pcFQ, pcFD;
   logic [PC_W-1:0]    pcIdQ, pcIdD;
   logic [INSTR_W-1:0] instrQ, instrD;
   logic               validQ, validD;
   logic [RedirW-1:0]  redirQ, redirD;
   logic               redirect;
   logic [PC_W-1:0]    target;

   fetch_pc_target #(
      .PC_W  (PC_W),
      .OFF_W (OFF_W)
   ) u_target (
      .iStall       (iStall),
      .iJmpEnable   (iJmpEnable),
      .iJmpDir      (iJmpDir),
      .iBranchTaken (iBranchTaken),
      .iBranchPC    (iBranchPC),
      .iBranchOff   (iBranchOff),
      .iPC          (pcQ),
      .iPCF         (pcFQ),
      .oRedirect    (redirect),
      .oTarget      (target),
      .oRomAddr     (oRomAddr)
   );

   always_comb begin
      stateD = stateQ;
      pcD    = pcQ;
      pcFD   = pcFQ;
      pcIdD  = pcIdQ;
      instrD = instrQ;
      validD = validQ;
      redirD = redirQ;
      if (redirect) begin
         // Target word is requested this cycle, so the FSM can go straight to run.
         validD = 1'b0;
         pcFD   = target;
         pcD    = target + PC_W'(1);
         stateD = StRun;
         if (redirQ != {RedirW{1'b1}}) begin
            redirD = redirQ + RedirW'(1);
         end
      end else if (!iStall) begin
         instrD = iRomInstr;
         pcIdD  = pcFQ;
         validD = (stateQ == StRun);
         pcFD   = pcQ;
         pcD    = pcQ + PC_W'(1);
         stateD = StRun;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         stateQ <= StFill;
         pcQ    <= ResetPc;
         pcFQ   <= ResetPc;
         pcIdQ  <= '0;
         instrQ <= INSTR_W'(Bubble);
         validQ <= 1'b0;
         redirQ <= '0;
      end else begin
         stateQ <= stateD;
         pcQ    <= pcD;
         pcFQ   <= pcFD;
         pcIdQ  <= pcIdD;
         instrQ <= instrD;
         validQ <= validD;
         redirQ <= redirD;
      end
   end

   assign oInstrID   = instrQ;
   assign oPCID      = pcIdQ;
   assign oValidID   = validQ;
   assign oFlushEX   = redirect;
   assign oRedirects = redirQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: two instances (RESET_PC 0 and 1022) run in lockstep
// against an instruction-stream model of the fetch front end.
module tb_fetch_stage;

   logic       clk = 1'b0;
   logic       rst, stall, jmp, br;
   logic [9:0] jdir, bpc;
   logic [5:0] boff;

   logic [9:0]  romAddr [2];
   logic [15:0] romData [2];
   logic [15:0] instrId [2];
   logic [9:0]  pcId    [2];
   logic        validId [2];
   logic        flush   [2];
   logic [15:0] redirs  [2];

   int nChecks = 0;
   int nErrors = 0;

   // Model: next instruction due in ID, whether a bubble precedes it, and the ID contents.
   logic [9:0]  mNext  [2];
   logic        mPend  [2];
   logic        mValid [2];
   logic [15:0] mInstr [2];
   logic [9:0]  mPc    [2];
   int          mCnt   [2];
   logic        mInit  [2] = '{1'b0, 1'b0};
   logic        mRst   [2];

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(0)) dut0 (
      .Clock(clk), .Reset(rst), .iStall(stall), .iJmpEnable(jmp), .iJmpDir(jdir),
      .iBranchTaken(br), .iBranchPC(bpc), .iBranchOff(boff), .oRomAddr(romAddr[0]),
      .iRomInstr(romData[0]), .oInstrID(instrId[0]), .oPCID(pcId[0]), .oValidID(validId[0]),
      .oFlushEX(flush[0]), .oRedirects(redirs[0])
   );

   fetch_stage #(.RESET_PC(1022)) dut1 (
      .Clock(clk), .Reset(rst), .iStall(stall), .iJmpEnable(jmp), .iJmpDir(jdir),
      .iBranchTaken(br), .iBranchPC(bpc), .iBranchOff(boff), .oRomAddr(romAddr[1]),
      .iRomInstr(romData[1]), .oInstrID(instrId[1]), .oPCID(pcId[1]), .oValidID(validId[1]),
      .oFlushEX(flush[1]), .oRedirects(redirs[1])
   );

   function automatic logic [15:0] romFn(input logic [9:0] a);
      return {6'h2B ^ a[5:0], a};
   endfunction

   function automatic logic [9:0] resetPc(input int i);
      return (i == 0) ? 10'd0 : 10'd1022;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) romData[i] <= romFn(romAddr[i]);
   end

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic s, input logic j, input logic [9:0] jd,
                        input logic b, input logic [9:0] bp, input logic [5:0] bo);
      int         t;
      logic       redir;
      logic [9:0] tgt;
      logic [9:0] expAddr;
      rst = r; stall = s; jmp = j; jdir = jd; br = b; bpc = bp; boff = bo;
      #1;
      redir = j | b;
      t     = int'(bp) + int'($signed(bo));
      tgt   = j ? jd : 10'(((t % 1024) + 1024) % 1024);
      for (int i = 0; i < 2; i++) begin
         checkEq($sformatf("flush%0d", i), 32'(flush[i]), 32'(redir));
         if (mInit[i]) begin
            if (redir)              expAddr = tgt;
            else if (s || mPend[i]) expAddr = mNext[i];
            else                    expAddr = mNext[i] + 10'd1;
            checkEq($sformatf("romAddr%0d", i), 32'(romAddr[i]), 32'(expAddr));
         end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         mRst[i] = r;
         if (r) begin
            mInit[i]  = 1'b1;
            mNext[i]  = resetPc(i);
            mPend[i]  = 1'b1;
            mValid[i] = 1'b0;
            mInstr[i] = 16'h0000;
            mPc[i]    = 10'd0;
            mCnt[i]   = 0;
         end else if (redir) begin
            mValid[i] = 1'b0;
            mNext[i]  = tgt;
            mPend[i]  = 1'b0;
            if (mCnt[i] < 65535) mCnt[i]++;
         end else if (!s) begin
            if (mPend[i]) begin
               mValid[i] = 1'b0;
               mPend[i]  = 1'b0;
            end else begin
               mValid[i] = 1'b1;
               mInstr[i] = romFn(mNext[i]);
               mPc[i]    = mNext[i];
               mNext[i]  = mNext[i] + 10'd1;
            end
         end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (mInit[i]) begin
            checkEq($sformatf("valid%0d", i), 32'(validId[i]), 32'(mValid[i]));
            checkEq($sformatf("redirects%0d", i), 32'(redirs[i]), 32'(mCnt[i]));
            if (mValid[i] || mRst[i]) begin
               checkEq($sformatf("instr%0d", i), 32'(instrId[i]), 32'(mInstr[i]));
               checkEq($sformatf("pcId%0d", i), 32'(pcId[i]), 32'(mPc[i]));
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 6'd0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; jmp = 1'b0; br = 1'b0;
      jdir = '0; bpc = '0; boff = '0;
      cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 6'd0);
      cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 6'd0);
      idle(7);
      cycle(1'b0, 1'b0, 1'b1, 10'h200, 1'b0, 10'd0, 6'd0);
      idle(4);
      cycle(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd10, 6'b111100);
      idle(3);
      cycle(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd3, 6'b110000);
      idle(3);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 6'd0);
      idle(3);
      cycle(1'b0, 1'b1, 1'b1, 10'h040, 1'b1, 10'd100, 6'd5);
      idle(3);
      // Stall straight out of reset, and a redirect while still filling.
      cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 6'd0);
      cycle(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 6'd0);
      cycle(1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0, 6'd0);
      idle(3);
      cycle(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 10'd0, 6'd0);
      cycle(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd1000, 6'd20);
      idle(3);

      for (int k = 0; k < 3000; k++) begin
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 11) == 0, 10'($urandom), $urandom_range(0, 11) == 0,
               10'($urandom), 6'($urandom));
      end

      // Drive the redirect counter into saturation.
      for (int k = 0; k < 65540; k++) begin
         cycle(1'b0, 1'($urandom), 1'b1, 10'($urandom), 1'($urandom), 10'($urandom),
               6'($urandom));
      end
      idle(3);
      cycle(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd50, 6'd1);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
